mdu: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers.
- Its busy output feeds the stall logic, which gates the PC register's enable and the F/D pipeline-register enables; it drives the other end of the PC stall interface.
- Models multi-cycle latency (mult 5, div 10) so that hazard stalls are exercised exactly.

---
 rtl/mdu.sv | 83 ++++++++
 tb/tb_mdu.sv | 112 +++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: MIPS E-stage multiply/divide unit owning HI/LO; ports clk, reset, start, op, a, b -> busy, hi, lo; `define MDU_MADD_EN enables madd/maddu/msub/msubu
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q, op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q;
  logic        is_mul, is_div, sgn, neg_a, neg_b, b_zero, commit;
  logic [63:0] ax, bx, prod, res;
  logic [31:0] mag_a, mag_b, uq, ur, q, r;
  always_comb begin
    is_mul = op == 4'd1 || op == 4'd2;
`ifdef MDU_MADD_EN
    is_mul = is_mul || (op >= 4'd7 && op <= 4'd10);
`endif
    is_div = op == 4'd3 || op == 4'd4;
    sgn    = op_q == 4'd1 || op_q == 4'd3 || op_q == 4'd7 || op_q == 4'd9;
    ax     = {{32{sgn & a_q[31]}}, a_q};
    bx     = {{32{sgn & b_q[31]}}, b_q};
    prod   = ax * bx;
    neg_a  = sgn & a_q[31];
    neg_b  = sgn & b_q[31];
    mag_a  = neg_a ? -a_q : a_q;
    mag_b  = neg_b ? -b_q : b_q;
    b_zero = b_q == 32'd0;
    uq     = mag_a / (mag_b | {31'd0, b_zero});
    ur     = mag_a % (mag_b | {31'd0, b_zero});
    q      = (neg_a ^ neg_b) ? -uq : uq;
    r      = neg_a ? -ur : ur;
    res    = (op_q == 4'd3 || op_q == 4'd4) ? {r, q} : prod;
`ifdef MDU_MADD_EN
    res    = (op_q == 4'd7 || op_q == 4'd8) ? {hi_q, lo_q} + prod :
             (op_q == 4'd9 || op_q == 4'd10) ? {hi_q, lo_q} - prod : res;
`endif
    commit = !((op_q == 4'd3 || op_q == 4'd4) && b_zero);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start && op == 4'd5) hi_q <= a;
      if (start && op == 4'd6) lo_q <= a;
      if (start && (is_mul || is_div)) begin
        a_q     <= a;
        b_q     <= b;
        op_q    <= op;
        cnt_q   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        state_q <= RUN;
        busy_q  <= 1'b1;
      end
    end else if (cnt_q == 4'd1) begin
      if (commit) {hi_q, lo_q} <= res;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed-vector self-checking bench for mdu
module tb_mdu;
  logic        clk = 0, reset = 1, start = 0;
  logic [3:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy;
  logic [31:0] hi, lo;
  int          n_vec = 0, n_bad = 0;
  mdu dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1; op = o; a = x; b = y;
    step();
    start = 0; op = 0; a = 0; b = 0;
  endtask
  task automatic wait_idle(input string tag, input int n);
    int c = 0;
    while (busy && c < 40) begin
      step();
      c++;
    end
    chk(tag, c, n);
  endtask
  initial begin
    step(); step();
    reset = 0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    issue(1, 32'hFFFFFFFE, 3);
    chk("mult_busy0", {31'd0, busy}, 1);
    wait_idle("mult_cycles", 5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    issue(2, 32'hFFFFFFFE, 3);
    chk("multu_hold_hi", hi, 32'hFFFFFFFF);
    wait_idle("multu_cycles", 5);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);
    issue(3, 32'hFFFFFFF9, 2);
    wait_idle("div_cycles", 10);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    issue(3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("divovf_cycles", 10);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 0);
    issue(4, 100, 7);
    wait_idle("divu_cycles", 10);
    chk("divu_lo", lo, 14);
    chk("divu_hi", hi, 2);
    issue(5, 32'h1234, 0);
    chk("mthi_busy", {31'd0, busy}, 0);
    issue(6, 32'h5678, 0);
    chk("mtlo_busy", {31'd0, busy}, 0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mtlo_lo", lo, 32'h5678);
    issue(5, 32'h11, 0);
    issue(6, 32'h22, 0);
    issue(4, 100, 0);
    wait_idle("div0_cycles", 10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    issue(12, 32'h99, 1);
    chk("rsv_busy", {31'd0, busy}, 0);
    chk("rsv_hi", hi, 32'h11);
    issue(3, 100, 7);
    step(); step();
    issue(5, 32'hDEAD, 0);
    chk("ign_hi", hi, 32'h11);
    chk("ign_busy", {31'd0, busy}, 1);
    step(); step();
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    repeat (12) step();
    chk("abort_nocommit_hi", hi, 0);
    chk("abort_nocommit_lo", lo, 0);
    issue(6, 32'hFFFFFFFF, 0);
    issue(7, 1, 1);
`ifdef MDU_MADD_EN
    wait_idle("madd_cycles", 5);
    chk("madd_hi", hi, 1);
    chk("madd_lo", lo, 0);
    issue(9, 1, 1);
    wait_idle("msub_cycles", 5);
    chk("msub_hi", hi, 0);
    chk("msub_lo", lo, 32'hFFFFFFFF);
`else
    chk("madd_off_busy", {31'd0, busy}, 0);
    repeat (6) step();
    chk("madd_off_hi", hi, 0);
    chk("madd_off_lo", lo, 32'hFFFFFFFF);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
